// File: rtl/al_spi_flash_seq_pkg.sv
// Shared encodings for the SPI flash command sequencer: request ops,
// flash opcodes and FSM states.
package al_spi_flash_seq_pkg;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_PROG   = 2'd1;
    localparam logic [1:0] OP_SERASE = 2'd2;
    localparam logic [1:0] OP_CERASE = 2'd3;

    localparam logic [7:0] CMD_WREN   = 8'h06;
    localparam logic [7:0] CMD_PROG   = 8'h02;
    localparam logic [7:0] CMD_SERASE = 8'h20;
    localparam logic [7:0] CMD_CERASE = 8'hC7;
    localparam logic [7:0] CMD_RDSR   = 8'h05;

    localparam logic [1:0] ADDR_WR_SZ = 2'd2;

    typedef enum logic [2:0] {IDLE, WREN, OP, POLL, DONE} state_t;

    // 24-bit flash address sent MSB-first in the top three extra-data bytes
    function automatic logic [31:0] addr_frame(input logic [23:0] addr);
        return {addr, 8'h00};
    endfunction

endpackage

// File: rtl/al_spi_flash_seq.sv
// SPI flash operation sequencer: WREN / command / status-poll flow on top of a
// generic command master. AL_SPI_FLASH_SEQ_POLL_TIMEOUT_EN enables poll timeout.
module al_spi_flash_seq
    import al_spi_flash_seq_pkg::*;
#(
    parameter logic [15:0] POLL_LIMIT = 16'd65535,
    parameter logic [7:0]  READ_CMD   = 8'h0B,
    parameter logic [3:0]  FAST_DUMMY = 4'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [5:0]  req_len,
    output logic        resp_valid,
    output logic        resp_err,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_cmd,
    output logic [31:0] m_edata,
    output logic [1:0]  m_edata_wr_sz,
    output logic        m_edata_wr_valid,
    output logic [3:0]  m_dummy_sz,
    output logic        m_dummy_valid,
    output logic        m_mem_valid,
    output logic [5:0]  m_mem_length,
    output logic        m_mem_wr,
    input  logic [31:0] snp_wdata,
    input  logic [5:0]  snp_waddr,
    input  logic        snp_wvalid,
    input  logic        snp_wready
);

    state_t      state;
    logic [1:0]  op_q;
    logic [23:0] addr_q;
    logic [5:0]  len_q;
    logic [7:0]  status_q;
    logic        snp_beat;
    logic [7:0]  status_eff;
    logic        wip;

    // A status beat landing with m_ready must win over the stale latch
    assign snp_beat   = snp_wvalid && snp_wready && (snp_waddr == 6'd0) && (state == POLL);
    assign status_eff = snp_beat ? snp_wdata[7:0] : status_q;
    assign wip        = status_eff[0];

`ifdef AL_SPI_FLASH_SEQ_POLL_TIMEOUT_EN
    logic [15:0] poll_cnt;
    logic        err_q;
    logic        poll_timeout;
    logic        unused_bits;

    assign poll_timeout = ({1'b0, poll_cnt} + 17'd1) >= {1'b0, POLL_LIMIT};
    assign resp_err     = (state == DONE) && err_q;
    assign unused_bits  = ^{snp_wdata[31:8], status_eff[7:1]};
`else
    logic unused_bits;

    assign resp_err    = 1'b0;
    assign unused_bits = ^{snp_wdata[31:8], status_eff[7:1], POLL_LIMIT};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_READ;
            addr_q   <= '0;
            len_q    <= '0;
            status_q <= '0;
`ifdef AL_SPI_FLASH_SEQ_POLL_TIMEOUT_EN
            poll_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            if (snp_beat)
                status_q <= snp_wdata[7:0];
            case (state)
                IDLE: if (req_valid) begin
                    op_q   <= req_op;
                    addr_q <= req_addr;
                    len_q  <= req_len;
`ifdef AL_SPI_FLASH_SEQ_POLL_TIMEOUT_EN
                    err_q  <= 1'b0;
`endif
                    state  <= (req_op == OP_READ) ? OP : WREN;
                end
                WREN: if (m_ready) state <= OP;
                OP: if (m_ready) begin
`ifdef AL_SPI_FLASH_SEQ_POLL_TIMEOUT_EN
                    poll_cnt <= '0;
`endif
                    state <= (op_q == OP_READ) ? DONE : POLL;
                end
                POLL: if (m_ready) begin
`ifdef AL_SPI_FLASH_SEQ_POLL_TIMEOUT_EN
                    if (poll_cnt != 16'hFFFF)
                        poll_cnt <= poll_cnt + 16'd1;
                    if (!wip) begin
                        state <= DONE;
                    end else if (poll_timeout) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
`else
                    if (!wip)
                        state <= DONE;
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign m_valid    = (state == WREN) || (state == OP) || (state == POLL);

    // Fields depend only on state and captured request, so they hold until m_ready
    always_comb begin
        m_cmd            = 8'h00;
        m_edata          = 32'h0;
        m_edata_wr_sz    = 2'd0;
        m_edata_wr_valid = 1'b0;
        m_dummy_sz       = 4'd0;
        m_dummy_valid    = 1'b0;
        m_mem_valid      = 1'b0;
        m_mem_length     = 6'd0;
        m_mem_wr         = 1'b0;
        case (state)
            WREN: m_cmd = CMD_WREN;
            OP: begin
                case (op_q)
                    OP_READ: begin
                        m_cmd            = READ_CMD;
                        m_edata          = addr_frame(addr_q);
                        m_edata_wr_sz    = ADDR_WR_SZ;
                        m_edata_wr_valid = 1'b1;
                        m_dummy_sz       = FAST_DUMMY;
                        m_dummy_valid    = 1'b1;
                        m_mem_valid      = 1'b1;
                        m_mem_length     = len_q;
                        m_mem_wr         = 1'b1;
                    end
                    OP_PROG: begin
                        m_cmd            = CMD_PROG;
                        m_edata          = addr_frame(addr_q);
                        m_edata_wr_sz    = ADDR_WR_SZ;
                        m_edata_wr_valid = 1'b1;
                        m_mem_valid      = 1'b1;
                        m_mem_length     = len_q;
                    end
                    OP_SERASE: begin
                        m_cmd            = CMD_SERASE;
                        m_edata          = addr_frame(addr_q);
                        m_edata_wr_sz    = ADDR_WR_SZ;
                        m_edata_wr_valid = 1'b1;
                    end
                    default: m_cmd = CMD_CERASE;
                endcase
            end
            POLL: begin
                m_cmd       = CMD_RDSR;
                m_mem_valid = 1'b1;
                m_mem_wr    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
